// File: rtl/spi_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_ram_arbiter
// Function : Decodes the SPI slave command stream into shadow addresses and
//            RAM requests, and round-robin shares a single-port RAM between
//            SPI and a local host port.
// Options  : SPI_ADDR_AUTOINC_EN - post-increment shadow address on accepted
//            SPI RAM commands.
// Revision : 1.0 - initial release
// ============================================================================
module spi_ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           i_spi_rx_data,
  input  logic                 i_spi_rx_valid,
  output logic [DATA_W-1:0]    o_spi_tx_data,
  output logic                 o_spi_tx_valid,
  output logic                 o_spi_overflow,
  input  logic                 i_host_req,
  input  logic                 i_host_we,
  input  logic [ADDR_SIZE-1:0] i_host_addr,
  input  logic [DATA_W-1:0]    i_host_wdata,
  output logic                 o_host_gnt,
  output logic [DATA_W-1:0]    o_host_rdata,
  output logic                 o_host_rvalid,
  output logic                 o_ram_en,
  output logic                 o_ram_we,
  output logic [ADDR_SIZE-1:0] o_ram_addr,
  output logic [DATA_W-1:0]    o_ram_wdata,
  input  logic [DATA_W-1:0]    i_ram_rdata,
  output logic                 o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_SPI  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

  state_t                r_state;
  owner_t                r_owner;
  owner_t                r_last_gnt;

  logic [ADDR_SIZE-1:0]  r_wr_shadow;
  logic [ADDR_SIZE-1:0]  r_rd_shadow;
  logic                  r_pend_valid;
  logic                  r_pend_we;
  logic [ADDR_SIZE-1:0]  r_pend_addr;
  logic [DATA_W-1:0]     r_pend_data;
  logic                  r_spi_overflow;

  logic                  r_ram_en;
  logic                  r_ram_we;
  logic [ADDR_SIZE-1:0]  r_ram_addr;
  logic [DATA_W-1:0]     r_ram_wdata;
  logic                  r_host_gnt;
  logic [DATA_W-1:0]     r_host_rdata;
  logic                  r_host_rvalid;
  logic [DATA_W-1:0]     r_spi_tx_data;
  logic                  r_spi_tx_valid;

  logic [1:0]            w_cmd;
  logic [7:0]            w_payload;
  logic                  w_ram_cmd;
  logic                  w_pend_release;
  logic                  w_pend_load;
  logic                  w_pend_drop;
  logic                  w_pick_host;

  assign w_cmd     = i_spi_rx_data[9:8];
  assign w_payload = i_spi_rx_data[7:0];
  assign w_ram_cmd = i_spi_rx_valid & w_cmd[0];

  // The pending slot is freed during the SPI access cycle, so a command
  // arriving in that same cycle can take its place without overflowing.
  assign w_pend_release = (r_state == ST_ACCESS) && (r_owner == OWN_SPI);
  assign w_pend_load    = w_ram_cmd & (~r_pend_valid | w_pend_release);
  assign w_pend_drop    = w_ram_cmd & r_pend_valid & ~w_pend_release;

  assign w_pick_host = i_host_req & (~r_pend_valid | (r_last_gnt == OWN_SPI));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_shadow    <= '0;
      r_rd_shadow    <= '0;
      r_pend_valid   <= 1'b0;
      r_pend_we      <= 1'b0;
      r_pend_addr    <= '0;
      r_pend_data    <= '0;
      r_spi_overflow <= 1'b0;
    end else begin
      if (w_pend_load) begin
        r_pend_valid <= 1'b1;
        r_pend_we    <= ~w_cmd[1];
        r_pend_addr  <= w_cmd[1] ? r_rd_shadow : r_wr_shadow;
        r_pend_data  <= w_cmd[1] ? '0 : w_payload[DATA_W-1:0];
      end else if (w_pend_release) begin
        r_pend_valid <= 1'b0;
      end

      if (w_pend_drop) begin
        r_spi_overflow <= 1'b1;
      end

      if (i_spi_rx_valid && (w_cmd == 2'b00)) begin
        r_wr_shadow <= w_payload[ADDR_SIZE-1:0];
      end
      if (i_spi_rx_valid && (w_cmd == 2'b10)) begin
        r_rd_shadow <= w_payload[ADDR_SIZE-1:0];
      end
`ifdef SPI_ADDR_AUTOINC_EN
      if (w_pend_load && (w_cmd == 2'b01)) begin
        r_wr_shadow <= r_wr_shadow + 1'b1;
      end
      if (w_pend_load && (w_cmd == 2'b11)) begin
        r_rd_shadow <= r_rd_shadow + 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_owner        <= OWN_SPI;
      r_last_gnt     <= OWN_HOST;
      r_ram_en       <= 1'b0;
      r_ram_we       <= 1'b0;
      r_ram_addr     <= '0;
      r_ram_wdata    <= '0;
      r_host_gnt     <= 1'b0;
      r_host_rdata   <= '0;
      r_host_rvalid  <= 1'b0;
      r_spi_tx_data  <= '0;
      r_spi_tx_valid <= 1'b0;
    end else begin
      r_ram_en       <= 1'b0;
      r_host_gnt     <= 1'b0;
      r_host_rvalid  <= 1'b0;
      r_spi_tx_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_pend_valid || i_host_req) begin
            r_state     <= ST_ACCESS;
            r_owner     <= w_pick_host ? OWN_HOST : OWN_SPI;
            r_ram_en    <= 1'b1;
            r_ram_we    <= w_pick_host ? i_host_we    : r_pend_we;
            r_ram_addr  <= w_pick_host ? i_host_addr  : r_pend_addr;
            r_ram_wdata <= w_pick_host ? i_host_wdata : r_pend_data;
            r_host_gnt  <= w_pick_host;
          end
        end
        ST_ACCESS: begin
          r_last_gnt  <= r_owner;
          r_ram_we    <= 1'b0;
          r_ram_addr  <= '0;
          r_ram_wdata <= '0;
          r_state     <= r_ram_we ? ST_IDLE : ST_RESP;
        end
        ST_RESP: begin
          if (r_owner == OWN_HOST) begin
            r_host_rdata  <= i_ram_rdata;
            r_host_rvalid <= 1'b1;
          end else begin
            r_spi_tx_data  <= i_ram_rdata;
            r_spi_tx_valid <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_spi_tx_data  = r_spi_tx_data;
  assign o_spi_tx_valid = r_spi_tx_valid;
  assign o_spi_overflow = r_spi_overflow;
  assign o_host_gnt     = r_host_gnt;
  assign o_host_rdata   = r_host_rdata;
  assign o_host_rvalid  = r_host_rvalid;
  assign o_ram_en       = r_ram_en;
  assign o_ram_we       = r_ram_we;
  assign o_ram_addr     = r_ram_addr;
  assign o_ram_wdata    = r_ram_wdata;
  assign o_busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_ram_arbiter
// Function : Directed scoreboard bench for spi_ram_arbiter with a RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_ram_arbiter;

`ifdef SPI_ADDR_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] spi_rx_data;
  logic       spi_rx_valid;
  logic [7:0] spi_tx_data;
  logic       spi_tx_valid;
  logic       spi_overflow;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic       ram_en;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       busy;

  logic [7:0] mem [256];

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } ram_op_t;

  ram_op_t    sb_ram[$];
  logic [7:0] sb_spi[$];
  logic [7:0] sb_host[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_ram_arbiter #(.ADDR_SIZE(8), .DATA_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_spi_rx_data  (spi_rx_data),
    .i_spi_rx_valid (spi_rx_valid),
    .o_spi_tx_data  (spi_tx_data),
    .o_spi_tx_valid (spi_tx_valid),
    .o_spi_overflow (spi_overflow),
    .i_host_req     (host_req),
    .i_host_we      (host_we),
    .i_host_addr    (host_addr),
    .i_host_wdata   (host_wdata),
    .o_host_gnt     (host_gnt),
    .o_host_rdata   (host_rdata),
    .o_host_rvalid  (host_rvalid),
    .o_ram_en       (ram_en),
    .o_ram_we       (ram_we),
    .o_ram_addr     (ram_addr),
    .o_ram_wdata    (ram_wdata),
    .i_ram_rdata    (ram_rdata),
    .o_busy         (busy)
  );

  // Single-port RAM with one-cycle read latency
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ram_en) begin
        if (sb_ram.size() == 0) begin
          check("ram_unexpected", 32'(ram_en), 32'(0));
        end else begin
          ram_op_t e;
          e = sb_ram.pop_front();
          check("ram_we", 32'(ram_we), 32'(e.we));
          check("ram_addr", 32'(ram_addr), 32'(e.addr));
          if (e.we) check("ram_wdata", 32'(ram_wdata), 32'(e.data));
        end
      end
      if (spi_tx_valid) begin
        if (sb_spi.size() == 0) check("spi_tx_unexpected", 32'(spi_tx_valid), 32'(0));
        else                    check("spi_tx_data", 32'(spi_tx_data), 32'(sb_spi.pop_front()));
      end
      if (host_rvalid) begin
        if (sb_host.size() == 0) check("host_rvalid_unexpected", 32'(host_rvalid), 32'(0));
        else                     check("host_rdata", 32'(host_rdata), 32'(sb_host.pop_front()));
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_ram_en"},   32'(ram_en), 32'(0));
    check({tag, "_ram_we"},   32'(ram_we), 32'(0));
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'(0));
    check({tag, "_ram_wdata"},32'(ram_wdata), 32'(0));
    check({tag, "_host_gnt"}, 32'(host_gnt), 32'(0));
    check({tag, "_host_rv"},  32'(host_rvalid), 32'(0));
    check({tag, "_host_rd"},  32'(host_rdata), 32'(0));
    check({tag, "_tx_valid"}, 32'(spi_tx_valid), 32'(0));
    check({tag, "_tx_data"},  32'(spi_tx_data), 32'(0));
    check({tag, "_overflow"}, 32'(spi_overflow), 32'(0));
    check({tag, "_busy"},     32'(busy), 32'(0));
  endtask

  task automatic push_ram(input logic we, input logic [7:0] addr, input logic [7:0] data);
    ram_op_t e;
    e.we = we; e.addr = addr; e.data = data;
    sb_ram.push_back(e);
  endtask

  task automatic spi_cmd(input logic [1:0] cmd, input logic [7:0] pl);
    @(posedge clk); #1;
    spi_rx_valid = 1'b1;
    spi_rx_data  = {cmd, pl};
    @(posedge clk); #1;
    spi_rx_valid = 1'b0;
  endtask

  task automatic wait_gnt();
    int n = 0;
    while (!host_gnt && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("host_gnt_seen", 32'(host_gnt), 32'(1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb_ram.size() != 0 || sb_spi.size() != 0 || sb_host.size() != 0) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_reached", 32'(n < 60), 32'(1));
    @(posedge clk); #1;
  endtask

  task automatic tie(input logic [7:0] sa, input logic [7:0] sd,
                     input logic [7:0] ha, input logic [7:0] hd, input bit spi_first);
    spi_cmd(2'b00, sa);
    if (spi_first) begin
      push_ram(1'b1, sa, sd);
      push_ram(1'b1, ha, hd);
    end else begin
      push_ram(1'b1, ha, hd);
      push_ram(1'b1, sa, sd);
    end
    @(posedge clk); #1;
    spi_rx_valid = 1'b1;
    spi_rx_data  = {2'b01, sd};
    @(posedge clk); #1;
    spi_rx_valid = 1'b0;
    host_req     = 1'b1;
    host_we      = 1'b1;
    host_addr    = ha;
    host_wdata   = hd;
    wait_gnt();
    host_req = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; spi_rx_valid = 1'b0; spi_rx_data = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("in_reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_zero("post_reset");

    // SPI write: RAM strobe two cycles after the 01 strobe
    spi_cmd(2'b00, 8'h12);
    push_ram(1'b1, 8'h12, 8'hA5);
    @(posedge clk); #1;
    spi_rx_valid = 1'b1;
    spi_rx_data  = {2'b01, 8'hA5};
    @(posedge clk); #1;
    spi_rx_valid = 1'b0;
    check("wr_no_early_en", 32'(ram_en), 32'(0));
    @(posedge clk); #1;
    check("wr_en", 32'(ram_en), 32'(1));
    check("wr_busy", 32'(busy), 32'(1));
    wait_idle();

    // SPI read returns RAM data on the tx strobe
    spi_cmd(2'b10, 8'h12);
    push_ram(1'b0, 8'h12, 8'h00);
    sb_spi.push_back(8'hA5);
    spi_cmd(2'b11, 8'h5C);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("rd_tx_valid", 32'(spi_tx_valid), 32'(1));
    check("rd_tx_data", 32'(spi_tx_data), 32'hA5);
    @(posedge clk); #1;
    check("rd_tx_pulse", 32'(spi_tx_valid), 32'(0));
    wait_idle();

    // A command arriving in the pending slot's grant cycle is accepted
    spi_cmd(2'b00, 8'h70);
    push_ram(1'b1, 8'h70, 8'h01);
    push_ram(1'b1, AUTOINC ? 8'h71 : 8'h70, 8'h02);
    @(posedge clk); #1;
    spi_rx_valid = 1'b1; spi_rx_data = {2'b01, 8'h01};
    @(posedge clk); #1;
    spi_rx_valid = 1'b0;
    @(posedge clk); #1;
    spi_rx_valid = 1'b1; spi_rx_data = {2'b01, 8'h02};
    @(posedge clk); #1;
    spi_rx_valid = 1'b0;
    check("grant_cycle_no_ovf", 32'(spi_overflow), 32'(0));
    wait_idle();

    // Overflow: second 01 while the first is held behind a host read
    spi_cmd(2'b00, 8'h60);
    push_ram(1'b0, 8'h12, 8'h00);
    sb_host.push_back(8'hA5);
    push_ram(1'b1, 8'h60, 8'hC3);
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h12; host_wdata = 8'hEE;
    wait_gnt();
    host_req     = 1'b0;
    spi_rx_valid = 1'b1;
    spi_rx_data  = {2'b01, 8'hC3};
    @(posedge clk); #1;
    spi_rx_data  = {2'b01, 8'h3C};
    @(posedge clk); #1;
    spi_rx_valid = 1'b0;
    check("overflow_set", 32'(spi_overflow), 32'(1));
    wait_idle();
    check("overflow_sticky", 32'(spi_overflow), 32'(1));

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_zero("reset2");

    // Round-robin: first tie after reset goes to SPI; after an SPI grant, host wins
    tie(8'h40, 8'h77, 8'h30, 8'h5A, 1'b1);
    spi_cmd(2'b00, 8'h41);
    push_ram(1'b1, 8'h41, 8'h88);
    spi_cmd(2'b01, 8'h88);
    wait_idle();
    tie(8'h42, 8'h99, 8'h31, 8'h6B, 1'b0);

    // Shadow address behaviour across consecutive writes, including wrap
    spi_cmd(2'b00, 8'hFF);
    push_ram(1'b1, 8'hFF, 8'h11);
    spi_cmd(2'b01, 8'h11);
    wait_idle();
    push_ram(1'b1, AUTOINC ? 8'h00 : 8'hFF, 8'h22);
    spi_cmd(2'b01, 8'h22);
    wait_idle();

    // Reset during the RESP cycle of a host read drops the response
    push_ram(1'b0, 8'h12, 8'h00);
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h12; host_wdata = 8'h00;
    wait_gnt();
    host_req = 1'b0;
    @(posedge clk); #1;
    check("resp_busy", 32'(busy), 32'(1));
    #1;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("no_rvalid_after_rst", 32'(host_rvalid), 32'(0));
    end

    check("sb_ram_empty",  32'(sb_ram.size()),  32'(0));
    check("sb_spi_empty",  32'(sb_spi.size()),  32'(0));
    check("sb_host_empty", 32'(sb_host.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
